// File: rtl/aes_cipher_if.sv
// aes_cipher_if: shared plaintext/key byte inputs and shared ciphertext byte outputs of aes_cipher.
interface aes_cipher_if;
    logic       FreshRandom;
    logic [7:0] input1, input2, key1, key2;
    logic [7:0] output1, output2;
    logic       Done;
    modport master (output FreshRandom, input1, input2, key1, key2, input output1, output2, Done);
    modport slave (input FreshRandom, input1, input2, key1, key2, output output1, output2, Done);
endinterface

// File: rtl/aes_cipher.sv
// aes_cipher: byte-serial 2-share masked AES-128 encryption core.
// Define AES_FRESH_RANDOM_EN to let FreshRandom remask the S-boxes; otherwise it is tied to 0.
module aes_masked_sbox (
    input  logic       clk,
    input  logic       fr,
    input  logic [7:0] a0, a1,
    output logic [7:0] s0, s1
);
    function automatic logic [7:0] gmul(input logic [7:0] a, b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    function automatic logic [7:0] pw2(input logic [7:0] a, input int n);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < n; i++) r = gmul(r, r);
        return r;
    endfunction
    function automatic logic [7:0] aff(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
    endfunction
    // Inversion as x^254 = (x^15)^16 * x^14; each multiply keeps inner- and cross-domain terms in separate registers
    logic [7:0] z;
    logic [7:0] i10, i11, c10, c11, d0, d1;
    logic [7:0] x3_0, x3_1, x12_0, x12_1;
    logic [7:0] i20, i21, c20, c21, j20, j21, e20, e21;
    logic [7:0] x15_0, x15_1, x14_0, x14_1, x240_0, x240_1;
    logic [7:0] i30, i31, c30, c31, y0, y1;
    assign z = {8{fr}};
    assign x3_0 = i10 ^ c10;
    assign x3_1 = i11 ^ c11;
    assign x12_0 = pw2(x3_0, 2);
    assign x12_1 = pw2(x3_1, 2);
    assign x15_0 = i20 ^ c20;
    assign x15_1 = i21 ^ c21;
    assign x14_0 = j20 ^ e20;
    assign x14_1 = j21 ^ e21;
    assign x240_0 = pw2(x15_0, 4);
    assign x240_1 = pw2(x15_1, 4);
    assign y0 = i30 ^ c30;
    assign y1 = i31 ^ c31;
    always_ff @(posedge clk) begin
        i10 <= gmul(a0, pw2(a0, 1));
        i11 <= gmul(a1, pw2(a1, 1));
        c10 <= gmul(a0, pw2(a1, 1)) ^ z;
        c11 <= gmul(a1, pw2(a0, 1)) ^ z;
        d0 <= pw2(a0, 1);
        d1 <= pw2(a1, 1);
        i20 <= gmul(x12_0, x3_0);
        i21 <= gmul(x12_1, x3_1);
        c20 <= gmul(x12_0, x3_1) ^ z;
        c21 <= gmul(x12_1, x3_0) ^ z;
        j20 <= gmul(x12_0, d0);
        j21 <= gmul(x12_1, d1);
        e20 <= gmul(x12_0, d1) ^ z;
        e21 <= gmul(x12_1, d0) ^ z;
        i30 <= gmul(x240_0, x14_0);
        i31 <= gmul(x240_1, x14_1);
        c30 <= gmul(x240_0, x14_1) ^ z;
        c31 <= gmul(x240_1, x14_0) ^ z;
        s0 <= aff(y0) ^ 8'h63;
        s1 <= aff(y1);
    end
endmodule

module aes_cipher (
    input logic         clk,
    input logic         rst,
    aes_cipher_if.slave io
);
    typedef enum logic [1:0] {LOAD, ROUND, OUT} state_t;
    state_t state, state_nx;
    logic [4:0] cnt;
    logic [3:0] rnd, kidx;
    logic [127:0] st1, st2, k1, k2, nk1, nk2;
    logic [31:0] t1, t2;
    logic [7:0] rc, sb1, sb2, kb1, kb2, ks1, ks2;
    logic fr, load, last;
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [127:0] sr(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127 - 8*i -: 8] = s[127 - 8*((i % 4) + 4*(((i / 4) + (i % 4)) % 4)) -: 8];
        return o;
    endfunction
    function automatic logic [127:0] mc(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction
    function automatic logic [127:0] kexp(input logic [127:0] k, input logic [31:0] t, input logic [7:0] r);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ t ^ {r, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction
`ifdef AES_FRESH_RANDOM_EN
    assign fr = io.FreshRandom;
`else
    logic unused_fr;
    assign unused_fr = io.FreshRandom;
    assign fr = 1'b0;
`endif
    assign load = rst || state == LOAD;
    assign last = state == ROUND && cnt == 5'd20;
    // RotWord(w3) order: key bytes 13, 14, 15, 12 on round cycles 0..3
    assign kidx = {2'b11, cnt[1:0] + 2'd1};
    assign kb1 = k1[{~kidx, 3'b000} +: 8];
    assign kb2 = k2[{~kidx, 3'b000} +: 8];
    assign nk1 = kexp(k1, t1, rc);
    assign nk2 = kexp(k2, t2, 8'h00);
    aes_masked_sbox u_sb (.clk(clk), .fr(fr), .a0(st1[127:120]), .a1(st2[127:120]), .s0(sb1), .s1(sb2));
    aes_masked_sbox u_ksb (.clk(clk), .fr(fr), .a0(kb1), .a1(kb2), .s0(ks1), .s1(ks2));
    always_comb begin
        state_nx = state;
        if (rst) state_nx = LOAD;
        else if (state == LOAD && cnt == 5'd15) state_nx = ROUND;
        else if (last && rnd == 4'd10) state_nx = OUT;
    end
    always_ff @(posedge clk) begin
        state <= state_nx;
        if (rst) begin
            cnt <= 5'd1;
            rnd <= 4'd1;
        end else if (state == LOAD) begin
            cnt <= cnt == 5'd15 ? 5'd0 : cnt + 5'd1;
        end else if (state == ROUND) begin
            cnt <= last ? 5'd0 : cnt + 5'd1;
            rnd <= rnd + {3'b000, last};
        end
    end
    // Rounds shift S-box results in at the tail; after 20 shifts the state holds SubBytes in order
    always_ff @(posedge clk) begin
        if (load) begin
            st1 <= {st1[119:0], io.input1 ^ io.key1};
            st2 <= {st2[119:0], io.input2 ^ io.key2};
            k1 <= {k1[119:0], io.key1};
            k2 <= {k2[119:0], io.key2};
        end else if (state == ROUND) begin
            st1 <= last ? (rnd == 4'd10 ? sr(st1) : mc(sr(st1))) ^ nk1 : {st1[119:0], sb1};
            st2 <= last ? (rnd == 4'd10 ? sr(st2) : mc(sr(st2))) ^ nk2 : {st2[119:0], sb2};
            if (cnt >= 5'd4 && cnt < 5'd8) begin
                t1 <= {t1[23:0], ks1};
                t2 <= {t2[23:0], ks2};
            end
            if (last) begin
                k1 <= nk1;
                k2 <= nk2;
            end
        end else if (state == OUT) begin
            st1 <= {st1[119:0], st1[127:120]};
            st2 <= {st2[119:0], st2[127:120]};
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rc <= 8'h01;
            io.Done <= 1'b0;
            io.output1 <= 8'h00;
            io.output2 <= 8'h00;
        end else if (last) begin
            rc <= xt(rc);
        end else if (state == OUT) begin
            io.Done <= 1'b1;
            io.output1 <= st1[127:120];
            io.output2 <= st2[127:120];
        end
    end
endmodule

// File: tb/tb_aes_cipher.sv
// tb_aes_cipher: randomized-share encryption runs against FIPS-197 constants and a table-driven AES model.
module tb_aes_cipher;
    logic clk = 1'b0;
    logic rst = 1'b1;
    aes_cipher_if io();
    aes_cipher dut (.clk(clk), .rst(rst), .io(io.slave));
    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    bit fr_rand = 1'b0;
    logic [7:0] sbox_t [256];
    logic [127:0] last_ct;
    localparam logic [127:0] FIPS_PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_CT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    function automatic logic [7:0] gm(input logic [7:0] a, b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic init_sbox;
        logic [7:0] inv, c, s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, key);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0] rcon;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ key[127 - 8*i -: 8];
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rcon, 24'h0};
                rcon = gm(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]     = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c + 1] = t[4*c] ^ gm(t[4*c+1], 8'h02) ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c + 2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
                    s[4*c + 3] = gm(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
                end else begin
                    for (int k = 0; k < 4; k++) s[4*c + k] = t[4*c + k];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i % 4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    // Inputs are scrambled after every edge so that anything outside the load phase is junk
    task automatic tick;
        @(posedge clk);
        #1;
        io.FreshRandom = fr_rand ? 1'($urandom) : 1'b0;
        io.input1 = 8'($urandom);
        io.input2 = 8'($urandom);
        io.key1 = 8'($urandom);
        io.key2 = 8'($urandom);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        vectors++;
        if (io.Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", io.Done);
        end
        vectors++;
        if (io.output1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_output1: got %h want 00", io.output1);
        end
        vectors++;
        if (io.output2 !== 8'h00) begin
            errors++;
            $display("FAIL reset_output2: got %h want 00", io.output2);
        end
    endtask

    // k2mode: 0 key2=0 / input2 random, 1 key2 and input2 random, 2 key2=input2=0xFF
    task automatic test_encrypt(input string name, input logic [127:0] pt, key, exp, input int k2mode, input bit frr);
        logic [7:0] i2, k2;
        last_ct = exp;
        fr_rand = frr;
        for (int i = 0; i < 16; i++) begin
            i2 = k2mode == 2 ? 8'hff : 8'($urandom);
            k2 = k2mode == 2 ? 8'hff : (k2mode == 1 ? 8'($urandom) : 8'h00);
            io.input1 = pt[127 - 8*i -: 8] ^ i2;
            io.input2 = i2;
            io.key1 = key[127 - 8*i -: 8] ^ k2;
            io.key2 = k2;
            rst = (i == 0);
            tick();
            vectors++;
            if ({io.Done, io.output1, io.output2} !== 17'h0) begin
                errors++;
                $display("FAIL %s load edge %0d: done=%b out=%h/%h want 0/00/00", name, i, io.Done, io.output1, io.output2);
            end
        end
        rst = 1'b0;
        for (int e = 16; e < 226; e++) begin
            tick();
            vectors++;
            if ({io.Done, io.output1, io.output2} !== 17'h0) begin
                errors++;
                $display("FAIL %s busy edge %0d: done=%b out=%h/%h want 0/00/00", name, e, io.Done, io.output1, io.output2);
            end
        end
        for (int k = 0; k < 16; k++) begin
            tick();
            vectors++;
            if (io.Done !== 1'b1 || (io.output1 ^ io.output2) !== exp[127 - 8*k -: 8]) begin
                errors++;
                $display("FAIL %s ct byte %0d at edge %0d: done=%b byte=%h want 1/%h", name, k, 226 + k,
                         io.Done, io.output1 ^ io.output2, exp[127 - 8*k -: 8]);
            end
        end
    endtask

    task automatic test_abort;
        fr_rand = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rst = (i == 0);
            tick();
        end
        rst = 1'b0;
        for (int e = 16; e < 100; e++) tick();
        test_encrypt("abort_fips", FIPS_PT, FIPS_KEY, FIPS_CT, 1, 1'b1);
    endtask

    task automatic test_hold;
        for (int j = 0; j < 40; j++) begin
            tick();
            vectors++;
            if (io.Done !== 1'b1 || (io.output1 ^ io.output2) !== last_ct[127 - 8*(j % 16) -: 8]) begin
                errors++;
                $display("FAIL hold cycle %0d: done=%b byte=%h want 1/%h", j, io.Done,
                         io.output1 ^ io.output2, last_ct[127 - 8*(j % 16) -: 8]);
            end
        end
    endtask

    task automatic test_random;
        logic [127:0] pt, key;
        for (int n = 0; n < 3; n++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            test_encrypt("random", pt, key, aes_ref(pt, key), 1, 1'b1);
        end
    endtask

    initial begin
        io.FreshRandom = 1'b0;
        io.input1 = 8'h00;
        io.input2 = 8'h00;
        io.key1 = 8'h00;
        io.key2 = 8'h00;
        init_sbox();
        test_reset();
        test_encrypt("fips_key2_zero", FIPS_PT, FIPS_KEY, FIPS_CT, 0, 1'b1);
        test_encrypt("fips_masked", FIPS_PT, FIPS_KEY, FIPS_CT, 1, 1'b1);
        test_encrypt("fips_fr_zero", FIPS_PT, FIPS_KEY, FIPS_CT, 1, 1'b0);
        test_encrypt("zero_ff_shares", 128'h0, 128'h0, ZERO_CT, 2, 1'b1);
        test_abort();
        test_hold();
        test_random();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
